// File: rtl/offset_range_gen_if.sv
// Offset-pair input and edge-line request bus for offset_range_gen, all CORE_NUM lanes packed.
// range_err exists only when OFFSET_RANGE_CHECK_EN is defined.
interface offset_range_gen_if #(
  parameter int unsigned CORE_NUM        = 16,
  parameter int unsigned V_OFF_DWIDTH    = 32,
  parameter int unsigned EDGE_LINE_WIDTH = 2,
  parameter int unsigned LINE_AWIDTH     = V_OFF_DWIDTH - EDGE_LINE_WIDTH
);
  localparam int unsigned E = 1 << EDGE_LINE_WIDTH;

  logic [CORE_NUM*V_OFF_DWIDTH-1:0] uram_loffset;
  logic [CORE_NUM*V_OFF_DWIDTH-1:0] uram_roffset;
  logic [CORE_NUM-1:0]              uram_dvalid;
  logic [CORE_NUM-1:0]              front_stall;
  logic [CORE_NUM*LINE_AWIDTH-1:0]  edge_req_line_addr;
  logic [CORE_NUM*E-1:0]            edge_req_mask;
  logic [CORE_NUM-1:0]              edge_req_last;
  logic [CORE_NUM-1:0]              edge_req_valid;
  logic [CORE_NUM-1:0]              edge_req_ready;
`ifdef OFFSET_RANGE_CHECK_EN
  logic [CORE_NUM-1:0]              range_err;
`endif

  modport slave (
`ifdef OFFSET_RANGE_CHECK_EN
    output range_err,
`endif
    input  uram_loffset, uram_roffset, uram_dvalid, edge_req_ready,
    output front_stall, edge_req_line_addr, edge_req_mask, edge_req_last, edge_req_valid
  );

  modport master (
`ifdef OFFSET_RANGE_CHECK_EN
    input  range_err,
`endif
    output uram_loffset, uram_roffset, uram_dvalid, edge_req_ready,
    input  front_stall, edge_req_line_addr, edge_req_mask, edge_req_last, edge_req_valid
  );
endinterface

// File: rtl/offset_range_gen.sv
// Per-lane offset-pair FIFO plus range walker emitting one edge-line request per cycle.
// Optional OFFSET_RANGE_CHECK_EN adds a sticky range_err flag for reversed pairs and overflow.
module offset_range_gen #(
  parameter int unsigned CORE_NUM        = 16,
  parameter int unsigned V_OFF_DWIDTH    = 32,
  parameter int unsigned EDGE_LINE_WIDTH = 2,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned LINE_AWIDTH     = V_OFF_DWIDTH - EDGE_LINE_WIDTH
) (
  input  logic                clk_i,
  input  logic [CORE_NUM-1:0] rst_i,
  output logic [CORE_NUM-1:0] next_rst_o,
  offset_range_gen_if.slave   bus_io
);
  localparam int unsigned E    = 1 << EDGE_LINE_WIDTH;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  function automatic logic [E-1:0] line_mask(input logic [LINE_AWIDTH-1:0]  line,
                                             input logic [V_OFF_DWIDTH-1:0] lo,
                                             input logic [V_OFF_DWIDTH-1:0] hi);
    logic [V_OFF_DWIDTH-1:0] addr;
    line_mask = '0;
    for (int k = 0; k < E; k++) begin
      addr = {line, EDGE_LINE_WIDTH'(k)};
      line_mask[k] = (addr >= lo) && (addr < hi);
    end
  endfunction

  always_ff @(posedge clk_i) next_rst_o <= rst_i;

  logic [CORE_NUM-1:0]             valid_w, last_w, stall_w;
  logic [CORE_NUM*LINE_AWIDTH-1:0] line_w;
  logic [CORE_NUM*E-1:0]           mask_w;
`ifdef OFFSET_RANGE_CHECK_EN
  logic [CORE_NUM-1:0]             err_w;
  assign bus_io.range_err = err_w;
`endif

  for (genvar i = 0; i < CORE_NUM; i++) begin : g_lane
    logic [V_OFF_DWIDTH-1:0] in_lo, in_hi, head_lo, head_hi;
    logic [V_OFF_DWIDTH-1:0] mem_lo [FIFO_DEPTH];
    logic [V_OFF_DWIDTH-1:0] mem_hi [FIFO_DEPTH];
    logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]         count_q, count_d;
    logic                    in_valid, ready, empty, full, wr_en, pop, head_bad, free;
    state_e                  state_q, state_d;
    logic [V_OFF_DWIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [LINE_AWIDTH-1:0]  cur_line_q, cur_line_d, end_line_q, end_line_d;
    logic [LINE_AWIDTH-1:0]  head_first, head_end, next_line;
    logic [E-1:0]            mask_q, mask_d;
    logic                    last_q, last_d, stall_q;

    assign in_lo    = bus_io.uram_loffset[i*V_OFF_DWIDTH +: V_OFF_DWIDTH];
    assign in_hi    = bus_io.uram_roffset[i*V_OFF_DWIDTH +: V_OFF_DWIDTH];
    assign in_valid = bus_io.uram_dvalid[i];
    assign ready    = bus_io.edge_req_ready[i];

    assign empty      = (count_q == '0);
    assign full       = (count_q == CntW'(FIFO_DEPTH));
    assign wr_en      = in_valid && !full;
    assign head_lo    = mem_lo[rd_ptr_q];
    assign head_hi    = mem_hi[rd_ptr_q];
    assign head_first = LINE_AWIDTH'(head_lo >> EDGE_LINE_WIDTH);
    assign head_end   = LINE_AWIDTH'((head_hi - V_OFF_DWIDTH'(1)) >> EDGE_LINE_WIDTH);
    assign next_line  = cur_line_q + LINE_AWIDTH'(1);
    // The head can be taken when idle or when the last line leaves this cycle (no bubble).
    assign free       = (state_q == StIdle) || (ready && last_q);
    assign count_d    = count_q + CntW'(wr_en) - CntW'(pop);
`ifdef OFFSET_RANGE_CHECK_EN
    assign head_bad = (head_hi <= head_lo);
`else
    assign head_bad = (head_hi == head_lo);
`endif

    always_comb begin
      state_d    = state_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      cur_line_d = cur_line_q;
      end_line_d = end_line_q;
      mask_d     = mask_q;
      last_d     = last_q;
      pop        = 1'b0;
      if (state_q == StIssue && ready) begin
        if (last_q) begin
          state_d    = StIdle;
          cur_line_d = '0;
          mask_d     = '0;
          last_d     = 1'b0;
        end else begin
          cur_line_d = next_line;
          mask_d     = line_mask(next_line, lo_q, hi_q);
          last_d     = (next_line == end_line_q);
        end
      end
      if (free && !empty) begin
        pop = 1'b1;
        if (!head_bad) begin
          state_d    = StIssue;
          lo_d       = head_lo;
          hi_d       = head_hi;
          cur_line_d = head_first;
          end_line_d = head_end;
          mask_d     = line_mask(head_first, head_lo, head_hi);
          last_d     = (head_first == head_end);
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i[i]) begin
        state_q    <= StIdle;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        lo_q       <= '0;
        hi_q       <= '0;
        cur_line_q <= '0;
        end_line_q <= '0;
        mask_q     <= '0;
        last_q     <= 1'b0;
        stall_q    <= 1'b0;
      end else begin
        state_q    <= state_d;
        lo_q       <= lo_d;
        hi_q       <= hi_d;
        cur_line_q <= cur_line_d;
        end_line_q <= end_line_d;
        mask_q     <= mask_d;
        last_q     <= last_d;
        count_q    <= count_d;
        stall_q    <= (count_d >= CntW'(FIFO_DEPTH - 4));
        if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (wr_en && !rst_i[i]) begin
        mem_lo[wr_ptr_q] <= in_lo;
        mem_hi[wr_ptr_q] <= in_hi;
      end
    end

`ifdef OFFSET_RANGE_CHECK_EN
    logic err_q;
    always_ff @(posedge clk_i) begin
      if (rst_i[i]) err_q <= 1'b0;
      else          err_q <= err_q | (pop && (head_hi < head_lo)) | (in_valid && full);
    end
    assign err_w[i] = err_q;
`endif

    assign valid_w[i]                          = (state_q == StIssue);
    assign last_w[i]                           = last_q;
    assign stall_w[i]                          = stall_q;
    assign line_w[i*LINE_AWIDTH +: LINE_AWIDTH] = cur_line_q;
    assign mask_w[i*E +: E]                    = mask_q;
  end

  assign bus_io.edge_req_valid     = valid_w;
  assign bus_io.edge_req_last      = last_w;
  assign bus_io.front_stall        = stall_w;
  assign bus_io.edge_req_line_addr = line_w;
  assign bus_io.edge_req_mask      = mask_w;
endmodule

// File: tb/tb_offset_range_gen.sv
// Directed bench for offset_range_gen: reset, range walking, backpressure, stall and drain.
// Range-error checks are compiled in when OFFSET_RANGE_CHECK_EN is defined.
module tb_offset_range_gen;
  localparam int unsigned CN = 16;
  localparam int unsigned VW = 32;
  localparam int unsigned EW = 2;
  localparam int unsigned LA = VW - EW;
  localparam int unsigned E  = 1 << EW;

  logic          clk;
  logic [CN-1:0] rst;
  logic [CN-1:0] next_rst;
  int            n_tests;
  int            n_fail;

  offset_range_gen_if #(.CORE_NUM(CN), .V_OFF_DWIDTH(VW), .EDGE_LINE_WIDTH(EW)) bus ();

  offset_range_gen #(
    .CORE_NUM(CN), .V_OFF_DWIDTH(VW), .EDGE_LINE_WIDTH(EW), .FIFO_DEPTH(16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .next_rst_o (next_rst),
    .bus_io     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push(input int l, input logic [VW-1:0] lo, input logic [VW-1:0] hi);
    bus.uram_loffset[l*VW +: VW] = lo;
    bus.uram_roffset[l*VW +: VW] = hi;
    bus.uram_dvalid[l]           = 1'b1;
    tick();
    bus.uram_dvalid[l]           = 1'b0;
  endtask

  task automatic expect_req(input string tag, input int l, input logic [LA-1:0] line,
                            input logic [E-1:0] mask, input logic last);
    check({tag, "_valid"}, 64'(bus.edge_req_valid[l]), 64'(1));
    check({tag, "_line"}, 64'(bus.edge_req_line_addr[l*LA +: LA]), 64'(line));
    check({tag, "_mask"}, 64'(bus.edge_req_mask[l*E +: E]), 64'(mask));
    check({tag, "_last"}, 64'(bus.edge_req_last[l]), 64'(last));
  endtask

  task automatic expect_idle(input string tag, input int l);
    check({tag, "_valid"}, 64'(bus.edge_req_valid[l]), 64'(0));
  endtask

  int n_req;
  int n_bad;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = '1;
    bus.uram_loffset   = '0;
    bus.uram_roffset   = '0;
    bus.uram_dvalid    = '0;
    bus.edge_req_ready = '1;
    #1;
    repeat (10) tick();

    // Reset state and next_rst lag
    sample();
    check("rst_next_rst", 64'(next_rst), 64'(16'hffff));
    check("rst_valid", 64'(bus.edge_req_valid), 64'(0));
    check("rst_mask", bus.edge_req_mask, 64'(0));
    tick();
    rst = '0;
    sample();
    check("next_rst_lag", 64'(next_rst), 64'(16'hffff));
    tick();
    sample();
    check("next_rst_clear", 64'(next_rst), 64'(0));
    check("idle_valid", 64'(bus.edge_req_valid), 64'(0));
    check("idle_stall", 64'(bus.front_stall), 64'(0));
    check("idle_line", 64'(|bus.edge_req_line_addr), 64'(0));
    check("idle_last", 64'(bus.edge_req_last), 64'(0));
    tick();

    // Lane 0: [5,14) spans lines 1..3
    push(0, 5, 14);
    sample();
    expect_idle("l0_t1", 0);
    tick();
    sample();
    expect_req("l0_line1", 0, 1, 4'b1110, 1'b0);
    check("l0_others_silent", 64'(bus.edge_req_valid), 64'(16'h0001));
    tick();
    sample();
    expect_req("l0_line2", 0, 2, 4'b1111, 1'b0);
    tick();
    sample();
    expect_req("l0_line3", 0, 3, 4'b0011, 1'b1);
    tick();
    sample();
    expect_idle("l0_done", 0);
    tick();

    // Lane 3: zero-degree pair then [100,104)
    push(3, 100, 100);
    push(3, 100, 104);
    sample();
    expect_idle("l3_zero", 3);
    tick();
    sample();
    expect_req("l3_line25", 3, 25, 4'b1111, 1'b1);
    tick();
    sample();
    expect_idle("l3_done", 3);
    tick();

    // Lane 4: back-to-back ranges [0,4) and [4,9) with no bubble
    push(4, 0, 4);
    push(4, 4, 9);
    sample();
    expect_req("l4_r0", 4, 0, 4'b1111, 1'b1);
    tick();
    sample();
    expect_req("l4_r1a", 4, 1, 4'b1111, 1'b0);
    tick();
    sample();
    expect_req("l4_r1b", 4, 2, 4'b0001, 1'b1);
    tick();
    sample();
    expect_idle("l4_done", 4);
    tick();

    // Lane 1: [0,8) with ready held low
    bus.edge_req_ready[1] = 1'b0;
    push(1, 0, 8);
    tick();
    sample();
    expect_req("l1_first", 1, 0, 4'b1111, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      sample();
      expect_req("l1_hold", 1, 0, 4'b1111, 1'b0);
    end
    tick();
    bus.edge_req_ready[1] = 1'b1;
    sample();
    expect_req("l1_accept", 1, 0, 4'b1111, 1'b0);
    tick();
    sample();
    expect_req("l1_second", 1, 1, 4'b1111, 1'b1);
    tick();
    sample();
    expect_idle("l1_done", 1);
    tick();

    // Lane 2: one pair moves into the output register, so the 13th write brings the FIFO to 12
    bus.edge_req_ready[2] = 1'b0;
    for (int k = 0; k < 12; k++) push(2, 0, 4);
    bus.uram_loffset[2*VW +: VW] = 0;
    bus.uram_roffset[2*VW +: VW] = 4;
    bus.uram_dvalid[2]           = 1'b1;
    sample();
    check("l2_stall_at_11", 64'(bus.front_stall[2]), 64'(0));
    tick();
    bus.uram_dvalid[2] = 1'b0;
    sample();
    check("l2_stall_at_12", 64'(bus.front_stall[2]), 64'(1));
    expect_req("l2_head", 2, 0, 4'b1111, 1'b1);
    tick();
    bus.edge_req_ready[2] = 1'b1;
    n_req = 0;
    n_bad = 0;
    for (int c = 0; c < 40; c++) begin
      sample();
      if (bus.edge_req_valid[2]) begin
        n_req++;
        if (bus.edge_req_line_addr[2*LA +: LA] != '0 || bus.edge_req_mask[2*E +: E] != 4'b1111
            || !bus.edge_req_last[2]) n_bad++;
      end
      tick();
    end
    check("l2_drain_count", 64'(n_req), 64'(13));
    check("l2_drain_fields", 64'(n_bad), 64'(0));
    check("l2_stall_released", 64'(bus.front_stall[2]), 64'(0));

    // Lane 5: mid-range reset drops the active range and the queued pair
    push(5, 0, 40);
    push(5, 0, 4);
    sample();
    expect_req("l5_line0", 5, 0, 4'b1111, 1'b0);
    tick();
    rst[5] = 1'b1;
    sample();
    expect_req("l5_line1", 5, 1, 4'b1111, 1'b0);
    tick();
    rst[5] = 1'b0;
    sample();
    expect_idle("l5_after_rst", 5);
    check("l5_rst_mask", 64'(bus.edge_req_mask[5*E +: E]), 64'(0));
    check("l5_rst_line", 64'(bus.edge_req_line_addr[5*LA +: LA]), 64'(0));
    check("l5_next_rst", 64'(next_rst[5]), 64'(1));
    n_req = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      sample();
      if (bus.edge_req_valid[5]) n_req++;
    end
    check("l5_dropped", 64'(n_req), 64'(0));
    tick();

`ifdef OFFSET_RANGE_CHECK_EN
    // Reversed pair is discarded and flagged until reset
    push(0, 20, 10);
    tick();
    sample();
    expect_idle("err_no_req", 0);
    check("err_set", 64'(bus.range_err), 64'(16'h0001));
    tick();
    tick();
    sample();
    check("err_sticky", 64'(bus.range_err[0]), 64'(1));
    tick();
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    sample();
    check("err_cleared", 64'(bus.range_err[0]), 64'(0));
    tick();
    // Lane 6 overflow: 1 in output register + 16 buffered, 18th write is dropped
    bus.edge_req_ready[6] = 1'b0;
    for (int k = 0; k < 17; k++) push(6, 0, 4);
    sample();
    check("ovf_not_yet", 64'(bus.range_err[6]), 64'(0));
    tick();
    push(6, 0, 4);
    sample();
    check("ovf_set", 64'(bus.range_err[6]), 64'(1));
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
